// File: rtl/sub_seq_ctrl.sv
// Sequential nibble-serial subtractor: one 4-bit borrow-ripple slice reused LSB nibble first.
// Optional comparison flags are enabled by defining SUB_SEQ_CMP_EN.
module sub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   x,
  input  logic [4*NIBBLES-1:0]   y,
  input  logic                   abort,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   d,
  output logic                   bout,
  output logic                   lt,
  output logic                   eq,
  output logic                   gt
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [IW-1:0] idx_reg;
  logic [W-1:0]  x_reg, y_reg, d_reg, d_next;
  logic          borrow_reg, bout_reg;

  logic [3:0]    x_nib [NIBBLES];
  logic [3:0]    y_nib [NIBBLES];
  logic [3:0]    x_cur, y_cur, slice_d;
  logic [4:0]    chain;
  logic          accept, step, last_nib;

  assign accept   = (state_reg == IDLE) && in_valid && !abort;
  assign step     = (state_reg == RUN) && !abort;
  assign last_nib = (idx_reg == IW'(NIBBLES - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign x_nib[gi] = x_reg[4*gi +: 4];
      assign y_nib[gi] = y_reg[4*gi +: 4];
      // Only the nibble under the index is rewritten; the others hold.
      assign d_next[4*gi +: 4] = (idx_reg == IW'(gi)) ? slice_d : d_reg[4*gi +: 4];
    end
  endgenerate

  assign x_cur    = x_nib[idx_reg];
  assign y_cur    = y_nib[idx_reg];
  assign chain[0] = borrow_reg;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign slice_d[gi]  = x_cur[gi] ^ y_cur[gi] ^ chain[gi];
      assign chain[gi+1]  = (~x_cur[gi] & y_cur[gi]) | (~(x_cur[gi] ^ y_cur[gi]) & chain[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            x_reg      <= x;
            y_reg      <= y;
            borrow_reg <= 1'b0;
            idx_reg    <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
          end else begin
            d_reg      <= d_next;
            borrow_reg <= chain[4];
            if (last_nib) begin
              bout_reg  <= chain[4];
              state_reg <= DONE;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SUB_SEQ_CMP_EN
  logic zero_reg, lt_reg, eq_reg, gt_reg, zero_now;

  // Running zero flag: difference is zero only if every nibble came out zero.
  assign zero_now = zero_reg & (slice_d == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
      lt_reg   <= 1'b0;
      eq_reg   <= 1'b0;
      gt_reg   <= 1'b0;
    end else if (accept) begin
      zero_reg <= 1'b1;
    end else if (step) begin
      zero_reg <= zero_now;
      if (last_nib) begin
        lt_reg <= chain[4];
        eq_reg <= zero_now;
        gt_reg <= ~chain[4] & ~zero_now;
      end
    end
  end

  assign lt = lt_reg;
  assign eq = eq_reg;
  assign gt = gt_reg;
`else
  assign lt = 1'b0;
  assign eq = 1'b0;
  assign gt = 1'b0;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign d         = d_reg;
  assign bout      = bout_reg;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed bench for sub_seq_ctrl (NIBBLES=4) with a result scoreboard queue.
// Flag expectations follow SUB_SEQ_CMP_EN when the bench is built with it.
module tb_sub_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, abort, out_valid, out_ready;
  logic        bout, lt, eq, gt;
  logic [15:0] x, y, d;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] d;
    logic        bout, lt, eq, gt;
  } exp_t;
  exp_t sb[$];

  sub_seq_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.d    = a - b;
    e.bout = (a < b);
`ifdef SUB_SEQ_CMP_EN
    e.lt = (a < b);
    e.eq = (a == b);
    e.gt = (a > b);
`else
    e.lt = 1'b0;
    e.eq = 1'b0;
    e.gt = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer operands at a negedge in IDLE, then scramble inputs after the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    x = a;
    y = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    in_valid = 1'b0;
    x = 16'($urandom);
    y = 16'($urandom);
    chk("accepted", {31'd0, in_ready}, 32'd0);
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_done(input string tag);
    int e;
    e = 0;
    while (out_valid !== 1'b1 && e < 20) begin
      @(negedge clk);
      e++;
    end
    chk({tag, "_latency"}, e, 32'd4);
  endtask

  task automatic check_result(input string tag, output exp_t e);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      e = '{default: '0};
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_d"}, {16'd0, d}, {16'd0, e.d});
      chk({tag, "_bout"}, {31'd0, bout}, {31'd0, e.bout});
      chk({tag, "_flags"}, {29'd0, lt, eq, gt}, {29'd0, e.lt, e.eq, e.gt});
      $display("txn %s: d=%h bout=%b lt/eq/gt=%b%b%b exp d=%h bout=%b", tag, d, bout, lt, eq, gt,
               e.d, e.bout);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_consumed_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_consumed_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic full_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    issue(a, b);
    wait_done(tag);
    check_result(tag, e);
    consume(tag);
  endtask

  initial begin
    exp_t e;
    int   last_cyc;
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    x = '0; y = '0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_d", {16'd0, d}, 32'd0);
    chk("rst_bout_flags", {28'd0, bout, lt, eq, gt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    full_op("sub_1234_0234", 16'h1234, 16'h0234);
    full_op("sub_0000_0001", 16'h0000, 16'h0001);
    full_op("sub_a5a5_a5a5", 16'hA5A5, 16'hA5A5);
    full_op("sub_ffff_0000", 16'hFFFF, 16'h0000);

    // Hold in DONE with in_valid and x toggling.
    issue(16'h8000, 16'h7FFF);
    wait_done("hold");
    check_result("hold", e);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      x = 16'($urandom);
      @(negedge clk);
      chk("hold_d", {16'd0, d}, {16'd0, e.d});
      chk("hold_state", {29'd0, bout, in_ready, out_valid}, {29'd0, e.bout, 1'b0, 1'b1});
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("hold_release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    @(negedge clk);
    chk("hold_no_accept", {31'd0, in_ready}, 32'd1);
    $display("txn hold_release: in_ready=%b out_valid=%b", in_ready, out_valid);

    // Reset one cycle after accept.
    in_valid = 1'b1; x = 16'h4321; y = 16'h1111;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_run_outputs", {12'd0, d, bout, in_ready, out_valid, 1'b0},
        {12'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_run_no_valid", {31'd0, out_valid}, 32'd0);
    end
    $display("txn reset_in_run: out_valid=%b d=%h", out_valid, d);

    // Abort during RUN.
    in_valid = 1'b1; x = 16'h0F0F; y = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_run_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    chk("abort_run_bout", {31'd0, bout}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_run_no_valid", {31'd0, out_valid}, 32'd0);
    end
    $display("txn abort_in_run: in_ready=%b out_valid=%b", in_ready, out_valid);

    // Abort during DONE keeps the result registers.
    issue(16'h0F0F, 16'h00F0);
    wait_done("abort_done");
    check_result("abort_done", e);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    chk("abort_done_d", {15'd0, d, bout}, {15'd0, e.d, e.bout});

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      in_valid = 1'b1;
      x = a;
      y = b;
      sb.push_back(model(a, b));
      begin
        int e2;
        e2 = 0;
        while (out_valid !== 1'b1 && e2 < 20) begin
          @(negedge clk);
          e2++;
          if (in_ready === 1'b0) begin
            x = 16'($urandom);
            y = 16'($urandom);
          end
        end
        chk("b2b_reached_done", {31'd0, out_valid}, 32'd1);
      end
      if (i > 0) chk("b2b_period", cyc - last_cyc, 32'd6);
      last_cyc = cyc;
      check_result("b2b", e);
      @(negedge clk);
      in_valid = 1'b0;
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_end_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
